// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the two-input gate vector sequencer.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } gate_seq_state_e;

    localparam int         NUM_VECTORS = 4;
    localparam logic [3:0] AND_TT      = 4'b1000;

endpackage

// File: rtl/gate_vector_sequencer.sv
// Walks a two-input gate through vectors 00,01,10,11, holds each for
// SETTLE_CYCLES, samples y once per vector and reports a pass/fail summary.
//
//   state  | meaning
//   IDLE   | waiting for start; results of the last run stay visible
//   SETTLE | current vector driven on a/b, settle counter running down
//   SAMPLE | one cycle: y compared with EXPECT_TT[idx]
//   DONE   | one cycle: done pulse, pass valid
module gate_vector_sequencer
    import gate_seq_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXPECT_TT     = AND_TT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [1:0] LAST_IDX    = 2'(NUM_VECTORS - 1);

    gate_seq_state_e state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [2:0]      err_q, err_d;
    logic [3:0]      fail_q, fail_d;
    logic            pass_q, pass_d;
    logic            mismatch;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort only matters while a run is in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort)               state_d = ST_IDLE;
                else if (cnt_q <= 4'd1)  state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)                  state_d = ST_IDLE;
                else if (idx_q == LAST_IDX) state_d = ST_DONE;
                else                        state_d = ST_SETTLE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: settle down-counter, vector index and result bookkeeping.
    always_comb begin
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        fail_d   = fail_q;
        pass_d   = pass_q;
        mismatch = (y != EXPECT_TT[idx_q]);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d  = 2'd0;
                    cnt_d  = SETTLE_LOAD;
                    err_d  = 3'd0;
                    fail_d = 4'd0;
                    pass_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    idx_d  = 2'd0;
                    cnt_d  = 4'd0;
                    err_d  = 3'd0;
                    fail_d = 4'd0;
                    pass_d = 1'b0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                // Abort discards this vector's comparison as well.
                if (abort) begin
                    idx_d  = 2'd0;
                    cnt_d  = 4'd0;
                    err_d  = 3'd0;
                    fail_d = 4'd0;
                    pass_d = 1'b0;
                end else begin
                    if (mismatch) begin
                        err_d         = err_q + 3'd1;
                        fail_d[idx_q] = 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        pass_d = (err_d == 3'd0);
                    end else begin
                        idx_d = idx_q + 2'd1;
                        cnt_d = SETTLE_LOAD;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= 2'd0;
            cnt_q  <= 4'd0;
            err_q  <= 3'd0;
            fail_q <= 4'd0;
            pass_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            fail_q <= fail_d;
            pass_q <= pass_d;
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_SETTLE, ST_SAMPLE: busy = 1'b1;
            ST_DONE:              done = 1'b1;
            default: ;
        endcase
    end

    assign a         = idx_q[1];
    assign b         = idx_q[0];
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule
